// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch control block: FSM states,
// BCD digit/time types and a ripple-carry BCD increment helper.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSE,
    ST_LAP
  } sw_state_e;

  typedef logic [3:0] bcd_digit_t;

  typedef struct packed {
    bcd_digit_t min;
    bcd_digit_t sec_tens;
    bcd_digit_t sec_ones;
    bcd_digit_t tenths;
  } bcd_time_t;

  localparam bcd_digit_t DIGIT_MAX    = 4'd9;
  localparam bcd_digit_t SEC_TENS_MAX = 4'd5;
  localparam bcd_time_t  TIME_MAX     = {DIGIT_MAX, SEC_TENS_MAX, DIGIT_MAX, DIGIT_MAX};

  // Advance M:SS.t by one tenth; 9:59.9 rolls over to 0:00.0.
  function automatic bcd_time_t bcd_inc(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.tenths != DIGIT_MAX) begin
      r.tenths = t.tenths + 4'd1;
    end else begin
      r.tenths = '0;
      if (t.sec_ones != DIGIT_MAX) begin
        r.sec_ones = t.sec_ones + 4'd1;
      end else begin
        r.sec_ones = '0;
        if (t.sec_tens != SEC_TENS_MAX) begin
          r.sec_tens = t.sec_tens + 4'd1;
        end else begin
          r.sec_tens = '0;
          r.min      = (t.min != DIGIT_MAX) ? t.min + 4'd1 : '0;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/stopwatch_tick_gen.sv
// Prescaler for the stopwatch timebase: counts 0..TICK_DIV-1 while enabled and
// flags the terminal count; holds its value while disabled.
module stopwatch_tick_gen #(
  parameter int TICK_DIV = 10
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int            CW   = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == LAST);

  always_comb begin
    // NOTE: default first so every path assigns cnt_d and no latch is inferred.
    cnt_d = cnt_q;
    if (clear_i || tick_o) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking so every register samples pre-edge values.
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch run/pause/lap FSM, BCD M:SS.t counter and registered display value.
// Lap freeze support is built only when STOPWATCH_LAP_EN is defined.
module stopwatch_ctrl #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int TICK_HZ     = 10
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_stop_i,
  input  logic        clear_i,
  input  logic        lap_i,
  output logic [15:0] display_o,
  output logic        running_o,
  output logic        lap_active_o,
  output logic        wrap_o
);
  import stopwatch_pkg::*;

  localparam int TICK_DIV = CLK_FREQ_HZ / TICK_HZ;

  if (((CLK_FREQ_HZ % TICK_HZ) != 0) || (TICK_DIV < 2)) begin : g_bad_tick_div
    $error("stopwatch_ctrl: CLK_FREQ_HZ must be a multiple of TICK_HZ with ratio >= 2");
  end

  sw_state_e   state_q, state_d;
  bcd_time_t   count_q, count_d;
  logic [15:0] display_q, display_d;
  logic        running_q, wrap_q, wrap_d;
  logic        counting, presc_clr, tick;

  assign counting  = (state_q == ST_RUN) || (state_q == ST_LAP);
  // Starting from idle restarts the prescaler; resuming from pause keeps it.
  assign presc_clr = clear_i || ((state_q == ST_IDLE) && start_stop_i);

  stopwatch_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (presc_clr),
    .en_i    (counting),
    .tick_o  (tick)
  );

`ifdef STOPWATCH_LAP_EN
  bcd_time_t lap_q, lap_d;
  logic      lap_active_q;
`else
  logic      unused_lap;
  assign unused_lap = lap_i;
`endif

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    wrap_d  = 1'b0;
`ifdef STOPWATCH_LAP_EN
    lap_d   = lap_q;
`endif
    if (tick) begin
      count_d = bcd_inc(count_q);
      wrap_d  = (count_q == TIME_MAX);
    end

    if (clear_i) begin
      state_d = ST_IDLE;
      count_d = '0;
      wrap_d  = 1'b0;
`ifdef STOPWATCH_LAP_EN
      lap_d   = '0;
`endif
    end else if (start_stop_i) begin
      case (state_q)
        ST_IDLE, ST_PAUSE: state_d = ST_RUN;
        default:           state_d = ST_PAUSE;
      endcase
`ifdef STOPWATCH_LAP_EN
    end else if (lap_i) begin
      // Capture uses count_d so a same-edge tick lands in the lap value.
      if (state_q == ST_RUN) begin
        state_d = ST_LAP;
        lap_d   = count_d;
      end else if (state_q == ST_LAP) begin
        state_d = ST_RUN;
      end
`endif
    end

`ifdef STOPWATCH_LAP_EN
    display_d = (state_d == ST_LAP) ? lap_d : count_d;
`else
    display_d = count_d;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      display_q    <= '0;
      running_q    <= 1'b0;
      wrap_q       <= 1'b0;
`ifdef STOPWATCH_LAP_EN
      lap_q        <= '0;
      lap_active_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      display_q    <= display_d;
      running_q    <= (state_d == ST_RUN) || (state_d == ST_LAP);
      wrap_q       <= wrap_d;
`ifdef STOPWATCH_LAP_EN
      lap_q        <= lap_d;
      lap_active_q <= (state_d == ST_LAP);
`endif
    end
  end

  assign display_o = display_q;
  assign running_o = running_q;
  assign wrap_o    = wrap_q;
`ifdef STOPWATCH_LAP_EN
  assign lap_active_o = lap_active_q;
`else
  assign lap_active_o = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: integer-tenths reference model checked
// every cycle, plus directed scenarios with hand-computed display values.
`timescale 1ns/1ps
module tb_stopwatch_ctrl;

  localparam int CLK_FREQ_HZ = 100;
  localparam int TICK_HZ     = 10;
  localparam int TICK_DIV    = CLK_FREQ_HZ / TICK_HZ;
`ifdef STOPWATCH_LAP_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif

  logic        clk        = 1'b0;
  logic        rst_n      = 1'b0;
  logic        start_stop = 1'b0;
  logic        clear      = 1'b0;
  logic        lap        = 1'b0;
  logic [15:0] display;
  logic        running;
  logic        lap_active;
  logic        wrap;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  always #5 clk = ~clk;

  stopwatch_ctrl #(
    .CLK_FREQ_HZ (CLK_FREQ_HZ),
    .TICK_HZ     (TICK_HZ)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_stop_i (start_stop),
    .clear_i      (clear),
    .lap_i        (lap),
    .display_o    (display),
    .running_o    (running),
    .lap_active_o (lap_active),
    .wrap_o       (wrap)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: elapsed time kept as a plain tenths count (0..5999).
  // Modes: 0 idle, 1 run, 2 pause, 3 lap.
  int m_mode     = 0;
  int m_presc    = 0;
  int m_time     = 0;
  int m_lap_time = 0;
  bit m_wrap     = 1'b0;

  function automatic logic [15:0] to_bcd(input int t);
    int s;
    s = (t / 10) % 60;
    return {4'(t / 600), 4'(s / 10), 4'(s % 10), 4'(t % 10)};
  endfunction

  always @(posedge clk) begin : model
    int mode, p, t, lt;
    bit w;
    mode = m_mode; p = m_presc; t = m_time; lt = m_lap_time; w = 1'b0;
    if (!rst_n) begin
      mode = 0; p = 0; t = 0; lt = 0;
    end else begin
      if (mode == 1 || mode == 3) begin
        if (p == TICK_DIV - 1) begin
          p = 0;
          t = (t + 1) % 6000;
          w = (t == 0);
        end else begin
          p = p + 1;
        end
      end
      if (clear) begin
        mode = 0; p = 0; t = 0; lt = 0; w = 1'b0;
      end else if (start_stop) begin
        if (mode == 0) begin
          mode = 1; p = 0;
        end else if (mode == 2) begin
          mode = 1;
        end else begin
          mode = 2;
        end
      end else if (lap && LAP_EN) begin
        if (mode == 1) begin
          mode = 3; lt = t;
        end else if (mode == 3) begin
          mode = 1;
        end
      end
    end
    m_mode     <= mode;
    m_presc    <= p;
    m_time     <= t;
    m_lap_time <= lt;
    m_wrap     <= w;
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_display", 32'(display), 32'((m_mode == 3) ? to_bcd(m_lap_time) : to_bcd(m_time)));
      check("model_running", 32'(running), 32'((m_mode == 1) || (m_mode == 3)));
      check("model_lap_active", 32'(lap_active), 32'(m_mode == 3));
      check("model_wrap", 32'(wrap), 32'(m_wrap));
    end
  end

  task automatic pulse(input bit ss, input bit clr, input bit lp);
    start_stop = ss; clear = clr; lap = lp;
    @(negedge clk);
    start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    check("reset_display", 32'(display), 32'h0000);
    check("reset_running", 32'(running), 32'h0);
    check("reset_lap_active", 32'(lap_active), 32'h0);
    check("reset_wrap", 32'(wrap), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Start, 25 cycles: ticks at +10 and +20.
    pulse(1'b1, 1'b0, 1'b0);
    wait_cycles(25);
    check("run25_display", 32'(display), 32'h0002);
    check("run25_running", 32'(running), 32'h1);
    pulse(1'b0, 1'b1, 1'b0);
    check("clear_display", 32'(display), 32'h0000);

    // Pause at +35 leaves prescaler at 5; resume needs 5 more cycles.
    pulse(1'b1, 1'b0, 1'b0);
    wait_cycles(34);
    pulse(1'b1, 1'b0, 1'b0);
    check("pause_display", 32'(display), 32'h0003);
    check("pause_running", 32'(running), 32'h0);
    wait_cycles(50);
    check("paused_hold", 32'(display), 32'h0003);
    pulse(1'b1, 1'b0, 1'b0);
    wait_cycles(4);
    check("resume_plus4", 32'(display), 32'h0003);
    wait_cycles(1);
    check("resume_plus5", 32'(display), 32'h0004);
    check("resume_running", 32'(running), 32'h1);
    pulse(1'b0, 1'b1, 1'b0);

    // Lap at +120 (same edge as the 12th tick), release at +150.
    pulse(1'b1, 1'b0, 1'b0);
    wait_cycles(119);
    pulse(1'b0, 1'b0, 1'b1);
    check("lap_capture", 32'(display), 32'h0012);
    check("lap_active_on", 32'(lap_active), 32'(LAP_EN));
    check("lap_running", 32'(running), 32'h1);
    wait_cycles(29);
    check("lap_frozen", 32'(display), LAP_EN ? 32'h0012 : 32'h0014);
    pulse(1'b0, 1'b0, 1'b1);
    check("lap_release", 32'(display), 32'h0015);
    check("lap_active_off", 32'(lap_active), 32'h0);

    // Clear beats start_stop on the same edge.
    pulse(1'b1, 1'b1, 1'b0);
    check("clr_ss_display", 32'(display), 32'h0000);
    check("clr_ss_running", 32'(running), 32'h0);
    wait_cycles(15);
    check("clr_ss_idle_hold", 32'(display), 32'h0000);

    // Reset mid-run at 0:03.7 with start_stop held during reset.
    pulse(1'b1, 1'b0, 1'b0);
    wait_cycles(370);
    check("pre_reset_display", 32'(display), 32'h0037);
    rst_n = 1'b0; start_stop = 1'b1;
    @(negedge clk);
    check("mid_reset_display", 32'(display), 32'h0000);
    check("mid_reset_running", 32'(running), 32'h0);
    @(negedge clk);
    rst_n = 1'b1; start_stop = 1'b0;
    wait_cycles(15);
    check("post_reset_display", 32'(display), 32'h0000);
    check("post_reset_running", 32'(running), 32'h0);

    // Full run up to and across the 9:59.9 rollover.
    pulse(1'b1, 1'b0, 1'b0);
    wait_cycles(59980);
    check("pre_wrap_9598", 32'(display), 32'h9598);
    wait_cycles(10);
    check("pre_wrap_9599", 32'(display), 32'h9599);
    check("pre_wrap_flag", 32'(wrap), 32'h0);
    wait_cycles(10);
    check("wrap_display", 32'(display), 32'h0000);
    check("wrap_flag", 32'(wrap), 32'h1);
    check("wrap_running", 32'(running), 32'h1);
    wait_cycles(1);
    check("wrap_one_cycle", 32'(wrap), 32'h0);
    wait_cycles(10);
    check("post_wrap_count", 32'(display), 32'h0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
